// File: rtl/servo_sequencer_pkg.sv
// servo_sequencer_pkg: package Servo with the servo position type, sequencer states
// and the default settle length in PWM periods.
package Servo;
   typedef enum logic {SERVO_POS_UP = 1'b0, SERVO_POS_DOWN = 1'b1} ServoPosition_t;
   typedef enum logic [2:0] {INIT, IDLE, SYNC, SETTLE, DONE} ServoSeqState_t;
   localparam int SERVO_SETTLE_PERIODS = 25;
endpackage

// File: rtl/servo_settle_timer.sv
// servo_settle_timer: saturating PWM-period counter; expired flags the tick that reaches target.
module servo_settle_timer #(
   parameter int CNT_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                tick,
   input  logic [CNT_BITS-1:0] target,
   output logic                expired
);
   logic [CNT_BITS-1:0] count;
   always_ff @(posedge clk) begin
      if (reset || clear) count <= '0;
      else if (tick && count != '1) count <= count + 1'b1;
   end
   // Combinational so the FSM leaves on the very tick that completes the count.
   assign expired = tick && (({1'b0, count} + (CNT_BITS+1)'(1)) == {1'b0, target});
endmodule

// File: rtl/servo_sequencer.sv
// servo_sequencer: pen servo command sequencer that moves on a PWM period boundary and settles.
// Optional SERVO_SEQ_SKIP_SAME_EN completes commands for the current position immediately.
module servo_sequencer
   import Servo::*;
#(
   parameter int SETTLE_PERIODS = SERVO_SETTLE_PERIODS,
   parameter int CNT_BITS       = $clog2(SETTLE_PERIODS + 1)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           period_tick,
   input  logic           cmd_valid,
   input  ServoPosition_t cmd_pos,
   output logic           cmd_ready,
   output ServoPosition_t servo_pos,
   output logic           busy,
   output logic           done
);
   ServoSeqState_t state, next;
   ServoPosition_t target_pos;
   logic accept, same, expired;
   assign accept = cmd_valid && cmd_ready;
`ifdef SERVO_SEQ_SKIP_SAME_EN
   assign same = cmd_pos == servo_pos;
`else
   assign same = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         servo_pos  <= SERVO_POS_UP;
         target_pos <= SERVO_POS_UP;
      end else begin
         state <= next;
         if (accept) target_pos <= cmd_pos;
         if (state == SYNC && period_tick) servo_pos <= target_pos;
      end
   end
   always_comb begin
      next      = state;
      cmd_ready = state == IDLE;
      busy      = state == INIT || state == SYNC || state == SETTLE;
      done      = state == DONE;
      unique case (state)
         INIT:    if (expired) next = IDLE;
         IDLE:    if (accept) next = same ? DONE : SYNC;
         SYNC:    if (period_tick) next = SETTLE;
         SETTLE:  if (expired) next = DONE;
         DONE:    next = IDLE;
         default: next = INIT;
      endcase
   end
   // The SYNC tick that applies the new position also restarts the settle count.
   servo_settle_timer #(.CNT_BITS(CNT_BITS)) timer (
      .clk(clk),
      .reset(reset),
      .clear(state == SYNC && period_tick),
      .tick(period_tick && (state == INIT || state == SETTLE)),
      .target(CNT_BITS'(SETTLE_PERIODS)),
      .expired(expired)
   );
endmodule

// File: doc/servo_sequencer.md
SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 Parameter SETTLE_PERIODS, default 25, servo PWM periods to wait after a position change (25 x 20 ms = 500 ms); legal range 1..255.
REQ-002 Parameter CNT_BITS, default $clog2(SETTLE_PERIODS+1), settle counter width.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 period_tick  input  1  one-cycle pulse at each servo PWM period boundary (every 20 ms).
REQ-006 cmd_valid  input  1  pen command request.
REQ-007 cmd_pos  input  Servo::ServoPosition_t  requested pen position.
REQ-008 cmd_ready  output  1  sequencer can accept a command.
REQ-009 servo_pos  output  Servo::ServoPosition_t  position driven to the servo PWM generator.
REQ-010 busy  output  1  position change or settle in progress; motion must hold.
REQ-011 done  output  1  one-cycle pulse when an accepted command has completed.

Function
REQ-012 States: INIT, IDLE, SYNC, SETTLE, DONE.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid && cmd_ready, and cmd_pos is captured then.
REQ-014 IDLE, accepted command differing from servo_pos: next state SYNC; servo_pos unchanged.
REQ-015 SYNC: on the first period_tick, servo_pos takes the captured position, counter clears to 0, next state SETTLE; a tick in the accept cycle is ignored.
REQ-016 SETTLE: each period_tick increments the counter; on the tick that makes it equal SETTLE_PERIODS, next state DONE.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE; cmd_ready=0 during DONE.
REQ-018 busy=1 in INIT, SYNC and SETTLE; 0 in IDLE and DONE.
REQ-019 Counter SHALL saturate and never wrap; ticks outside SYNC/SETTLE/INIT are ignored.
REQ-020 cmd_valid deasserted in IDLE: remain in IDLE, no output change.
REQ-021 Commands presented while not in IDLE are not accepted and need not be held by the sequencer.

Reset
REQ-022 On reset: state INIT, servo_pos=SERVO_POS_UP, counter=0, cmd_ready=0, busy=1, done=0.
REQ-023 INIT counts period_ticks like SETTLE; on reaching SETTLE_PERIODS it goes to IDLE with no done pulse.
REQ-024 Reset asserted mid-operation SHALL abort the command without a done pulse and force servo_pos to UP in the following cycle.

Configuration
REQ-025 Macro SERVO_SEQ_SKIP_SAME_EN defined: an accepted command equal to servo_pos goes IDLE -> DONE directly, so done is asserted the cycle after acceptance, with busy=0 throughout.
REQ-026 Macro undefined: every accepted command runs the full SYNC/SETTLE sequence, even when the position is unchanged.

Structure
REQ-027 Package Servo SHALL gain the ServoSeqState_t enum (INIT, IDLE, SYNC, SETTLE, DONE), and the header SHALL gain SERVO_SETTLE_PERIODS (25).
REQ-028 One sub-module, servo_settle_timer (clear, tick, target, expired output), SHALL hold the saturating counter.
REQ-029 servo_pos SHALL feed the existing servo PWM generator directly; period_tick SHALL come from that generator's period wrap.

Verification (SETTLE_PERIODS=3, period_tick every 10 cycles)
REQ-030 Reset release -> busy=1, cmd_ready=0, servo_pos=UP for 3 ticks; then IDLE, cmd_ready=1, no done.
REQ-031 DOWN command in IDLE -> servo_pos=DOWN at the next tick; done pulses once, the cycle after the 3rd subsequent tick; busy is high until then.
REQ-032 Command issued in the same cycle as a period_tick -> that tick is ignored; servo_pos changes at the following tick.
REQ-033 UP command while servo_pos=UP -> with SERVO_SEQ_SKIP_SAME_EN: done the cycle after acceptance and busy stays 0; without it: full 3-tick settle and then done.
REQ-034 Reset pulsed during SETTLE of a DOWN command -> servo_pos=UP next cycle, no done, INIT re-run of 3 ticks.
REQ-035 cmd_valid held high through back-to-back DOWN then UP commands -> exactly one done per accept, no acceptance during SYNC/SETTLE/DONE.
